// File: rtl/period_stimulus_gen_pkg.sv
// Shared constants and encodings for the periodic stimulus generator.
package period_stimulus_gen_pkg;

   localparam int DATA_W_DFLT         = 14;
   localparam int PER_W_DFLT          = 32;
   localparam int MIN_PERIOD_DFLT     = 4;
   localparam int DEFAULT_PERIOD_DFLT = 1000;

   function automatic int mid_of(input int w);
      return 1 << (w - 1);
   endfunction

   // Mid-scale level for the default sample width
   localparam int MID = mid_of(DATA_W_DFLT);

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'd0,
      WAVE_PULSE  = 2'd1,
      WAVE_DC     = 2'd2,
      WAVE_INV    = 2'd3
   } wave_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/period_stimulus_gen_phase_counter.sv
// Phase counter with wrap detection and a one-deep pending-period register.
module phase_counter
   import period_stimulus_gen_pkg::*;
#(
   parameter int PER_W          = PER_W_DFLT,
   parameter int MIN_PERIOD     = MIN_PERIOD_DFLT,
   parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [PER_W-1:0] period_in,
   input  logic             period_valid,
   output logic             period_ready,
   output logic [PER_W-1:0] phase,
   output logic [PER_W-1:0] period,
   output logic             wrap
);

   logic [PER_W-1:0] pending;
   logic             pending_vld;
   logic             accept;
   logic             apply;

   function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
      return (p < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : p;
   endfunction

   assign period_ready = !pending_vld;
   assign accept       = period_valid && period_ready;
   assign wrap         = run && (phase == (period - PER_W'(1)));
   // A pending period only lands on a period boundary, or at once when idle
   assign apply        = pending_vld && (!run || wrap);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase       <= '0;
         period      <= PER_W'(DEFAULT_PERIOD);
         pending     <= '0;
         pending_vld <= 1'b0;
      end else begin
         if (!run || wrap)
            phase <= '0;
         else
            phase <= phase + PER_W'(1);

         if (apply) begin
            period      <= pending;
            pending_vld <= 1'b0;
         end

         if (accept) begin
            pending     <= clamp_period(period_in);
            pending_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/period_stimulus_gen.sv
// Periodic test-stimulus generator: square, pulse, DC and inverted square
// waveforms with a run/idle FSM and period updates applied on boundaries.
module period_stimulus_gen
   import period_stimulus_gen_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DFLT,
   parameter int PER_W          = PER_W_DFLT,
   parameter int MIN_PERIOD     = MIN_PERIOD_DFLT,
   parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [PER_W-1:0]  period_in,
   input  logic              period_valid,
   output logic              period_ready,
   input  logic [1:0]        wave_sel,
   input  logic [DATA_W-1:0] amplitude,
   output logic [DATA_W-1:0] signal_out,
   output logic              cycle_start,
   output logic              active
);

   localparam logic [DATA_W-1:0] MID_L = DATA_W'(mid_of(DATA_W));

   state_t            state;
   logic              run;
   logic              wrap;
   logic              phase_zero;
   logic              square_hi;
   logic [PER_W-1:0]  phase;
   logic [PER_W-1:0]  period;
   wave_t             wsel_q;
   wave_t             wsel_p0;
   logic [DATA_W-1:0] amp_q;
   logic [DATA_W-1:0] amp_p0;
   logic [DATA_W-1:0] level_p0;

   // HI/LO stay inside [0, 2^DATA_W) because the half swing is below MID
   function automatic logic [DATA_W-1:0] level_hi(input logic [DATA_W-1:0] amp);
      return MID_L + (amp >> 1);
   endfunction

   function automatic logic [DATA_W-1:0] level_lo(input logic [DATA_W-1:0] amp);
      return MID_L - (amp >> 1);
   endfunction

   assign run         = (state == RUN);
   assign active      = run;
   assign phase_zero  = (phase == '0);
   assign cycle_start = run && phase_zero;

   phase_counter #(
      .PER_W          (PER_W),
      .MIN_PERIOD     (MIN_PERIOD),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
   ) u_phase_counter (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .period_in    (period_in),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .phase        (phase),
      .period       (period),
      .wrap         (wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (wrap && !enable) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p0: level selection; wave_sel/amplitude are live at phase 0, held after
   always_comb begin
      wsel_p0   = phase_zero ? wave_t'(wave_sel) : wsel_q;
      amp_p0    = phase_zero ? amplitude : amp_q;
      square_hi = (phase < (period >> 1));
      level_p0  = MID_L;
      case (wsel_p0)
         WAVE_SQUARE: level_p0 = square_hi  ? level_hi(amp_p0) : level_lo(amp_p0);
         WAVE_PULSE:  level_p0 = phase_zero ? level_hi(amp_p0) : level_lo(amp_p0);
         WAVE_DC:     level_p0 = MID_L;
         WAVE_INV:    level_p0 = square_hi  ? level_lo(amp_p0) : level_hi(amp_p0);
         default:     level_p0 = MID_L;
      endcase
   end

   always_ff @(posedge clk) begin
      if (run && phase_zero) begin
         wsel_q <= wsel_p0;
         amp_q  <= amp_p0;
      end
   end

   // Stage p1: registered sample, one cycle behind phase
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         signal_out <= MID_L;
      else
         signal_out <= run ? level_p0 : MID_L;
   end

endmodule

// File: tb/tb_period_stimulus_gen.sv
// Directed bench: expectations are queued per cycle and checked by a
// negedge monitor against the generator outputs.
module tb_period_stimulus_gen;

   localparam int SIG = 0;
   localparam int CS  = 1;
   localparam int ACT = 2;
   localparam int RDY = 3;

   typedef struct {
      int    cyc;
      int    kind;
      int    val;
      string name;
   } item_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] period_in;
   logic        period_valid;
   logic        period_ready;
   logic [1:0]  wave_sel;
   logic [13:0] amplitude;
   logic [13:0] signal_out;
   logic        cycle_start;
   logic        active;

   item_t sb[$];
   int    cyc      = 0;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    r;
   int    r2;
   int    tr;

   period_stimulus_gen dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .period_in    (period_in),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .wave_sel     (wave_sel),
      .amplitude    (amplitude),
      .signal_out   (signal_out),
      .cycle_start  (cycle_start),
      .active       (active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input int kind, input int val, input string name);
      item_t it;
      it.cyc  = c;
      it.kind = kind;
      it.val  = val;
      it.name = name;
      sb.push_back(it);
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin : monitor
      int actual;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            case (sb[i].kind)
               SIG:     actual = int'(signal_out);
               CS:      actual = int'(cycle_start);
               ACT:     actual = int'(active);
               RDY:     actual = int'(period_ready);
               default: actual = -1;
            endcase
            n_checks++;
            if (sb[i].cyc != cyc || actual != sb[i].val) begin
               n_fail++;
               $display("FAIL %s at cycle %0d (due %0d): got %0d, want %0d",
                        sb[i].name, cyc, sb[i].cyc, actual, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      enable       = 1'b1;
      period_in    = '0;
      period_valid = 1'b0;
      wave_sel     = 2'd0;
      amplitude    = 14'd16000;
      @(posedge clk);
      #1;

      // Reset values, with enable already high
      push(cyc + 1, SIG, 8192, "reset_signal_out");
      push(cyc + 1, CS,  0,    "reset_cycle_start");
      push(cyc + 1, ACT, 0,    "reset_active");
      push(cyc + 1, RDY, 1,    "reset_period_ready");
      goto(3);
      reset = 1'b1;
      r = cyc + 1;

      // Default period square wave, amplitude 16000
      push(r,        ACT, 1,    "run_active");
      push(r,        CS,  1,    "first_cycle_start");
      push(r + 1,    CS,  0,    "cs_phase1");
      push(r + 999,  CS,  0,    "cs_phase999");
      push(r + 1000, CS,  1,    "cs_period1000");
      push(r,        SIG, 8192, "sig_before_first_sample");
      for (int k = 0; k < 1000; k++)
         push(r + 1 + k, SIG, (k < 500) ? 16192 : 192, "square_p1000");

      // Period change offered mid-period
      goto(r + 1300);
      period_in    = 32'd10;
      period_valid = 1'b1;
      push(r + 1300, RDY, 1,     "ready_before_offer");
      push(r + 1301, RDY, 0,     "ready_after_accept");
      push(r + 1310, CS,  0,     "p_held_mid_period");
      push(r + 1999, RDY, 0,     "ready_until_wrap");
      push(r + 2000, RDY, 1,     "ready_after_apply");
      push(r + 2000, CS,  1,     "cs_at_apply_wrap");
      push(r + 2005, CS,  0,     "cs_p10_mid");
      push(r + 2010, CS,  1,     "cs_p10_second");
      push(r + 2005, SIG, 16192, "square_p10_hi");
      push(r + 2006, SIG, 192,   "square_p10_lo");
      goto(r + 1301);
      period_valid = 1'b0;

      // Enable blip and amplitude change within one period
      goto(r + 2021);
      push(r + 2024, SIG, 16192, "amp_held_hi");
      push(r + 2028, SIG, 192,   "amp_held_lo");
      push(r + 2030, ACT, 1,     "enable_blip_active");
      push(r + 2030, CS,  1,     "enable_blip_cs");
      push(r + 2031, SIG, 8193,  "amp_applied_at_phase0");
      enable = 1'b0;
      goto(r + 2022);
      amplitude = 14'd2;
      goto(r + 2024);
      enable = 1'b1;

      // Stop request at phase 3: period completes
      goto(r + 2033);
      enable = 1'b0;
      push(r + 2039, ACT, 1,    "active_through_phase9");
      push(r + 2040, ACT, 0,    "idle_after_wrap");
      push(r + 2040, CS,  0,    "no_cs_after_stop");
      push(r + 2040, SIG, 8191, "last_sample_lag");
      push(r + 2041, SIG, 8192, "idle_sig_mid");
      push(r + 2045, CS,  0,    "no_cs_idle");
      push(r + 2045, ACT, 0,    "still_idle");

      // Zero period in IDLE clamps to 4
      goto(r + 2046);
      period_in    = 32'd0;
      period_valid = 1'b1;
      push(r + 2046, RDY, 1, "idle_ready_before");
      push(r + 2047, RDY, 0, "idle_ready_pending");
      push(r + 2048, RDY, 1, "idle_ready_applied");
      goto(r + 2047);
      period_valid = 1'b0;
      goto(r + 2049);
      enable    = 1'b1;
      amplitude = 14'd16000;
      wave_sel  = 2'd0;
      r2 = cyc + 1;
      push(r2,     ACT, 1,     "p4_active");
      push(r2,     CS,  1,     "p4_cs0");
      push(r2 + 2, CS,  0,     "p4_cs_mid");
      push(r2 + 4, CS,  1,     "p4_cs4");
      push(r2 + 1, SIG, 16192, "p4_hi0");
      push(r2 + 2, SIG, 16192, "p4_hi1");
      push(r2 + 3, SIG, 192,   "p4_lo0");
      push(r2 + 4, SIG, 192,   "p4_lo1");

      // Period 7, amplitude 2: odd-period square split
      goto(r2 + 1);
      period_in    = 32'd7;
      period_valid = 1'b1;
      goto(r2 + 2);
      period_valid = 1'b0;
      amplitude    = 14'd2;
      push(r2 + 7,  CS, 0, "p7_cs_mid");
      push(r2 + 11, CS, 1, "p7_cs1");
      push(r2 + 18, CS, 1, "p7_cs2");
      for (int m = 0; m < 14; m++)
         push(r2 + 5 + m, SIG, ((m % 7) < 3) ? 8193 : 8191, "square_p7");

      // Pulse, inverted square and DC
      goto(r2 + 17);
      wave_sel = 2'd1;
      push(r2 + 19, SIG, 8193, "pulse_hi");
      for (int m = 0; m < 6; m++)
         push(r2 + 20 + m, SIG, 8191, "pulse_lo");
      goto(r2 + 24);
      wave_sel = 2'd3;
      for (int m = 0; m < 7; m++)
         push(r2 + 26 + m, SIG, (m < 3) ? 8191 : 8193, "inv_square_p7");
      goto(r2 + 31);
      wave_sel = 2'd2;
      for (int m = 0; m < 7; m++)
         push(r2 + 33 + m, SIG, 8192, "dc_mid");
      goto(r2 + 38);
      wave_sel  = 2'd0;
      amplitude = 14'd16000;

      // Reset at phase 5 with a pending period
      goto(r2 + 42);
      period_in    = 32'd20;
      period_valid = 1'b1;
      push(r2 + 43, RDY, 0,   "pending_before_reset");
      push(r2 + 43, SIG, 192, "sig_before_reset");
      goto(r2 + 43);
      period_valid = 1'b0;
      goto(r2 + 44);
      reset = 1'b0;
      push(r2 + 44, SIG, 8192, "abort_signal_out");
      push(r2 + 44, ACT, 0,    "abort_active");
      push(r2 + 44, RDY, 1,    "abort_period_ready");
      push(r2 + 44, CS,  0,    "abort_cycle_start");
      push(r2 + 45, ACT, 0,    "held_reset_active");
      goto(r2 + 46);
      reset = 1'b1;
      tr = cyc + 1;
      push(tr,        ACT, 1,     "restart_active");
      push(tr,        CS,  1,     "restart_cs");
      push(tr + 1,    CS,  0,     "restart_cs_phase1");
      push(tr + 1,    SIG, 16192, "restart_sig");
      push(tr + 7,    CS,  0,     "restart_not_p7");
      push(tr + 20,   CS,  0,     "restart_not_p20");
      push(tr + 999,  CS,  0,     "restart_cs_phase999");
      push(tr + 1000, CS,  1,     "restart_p1000");

      for (int i = 0; i < 3000 && sb.size() > 0; i++)
         @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
